// File: rtl/powerup_spawner.sv
// Pickup manager: per-item ACTIVE/COOLDOWN lifecycle, LFSR-seeded spawn-point
// selection with collision-free linear probing, and a combinational pixel hit test.
module powerup_spawner #(
   parameter int                      NUM_ITEMS       = 2,
   parameter int                      NUM_SPAWN       = 5,
   parameter logic [10*NUM_SPAWN-1:0] SPAWN_X         = {10'd610, 10'd30, 10'd461, 10'd180, 10'd320},
   parameter logic [10*NUM_SPAWN-1:0] SPAWN_Y         = {10'd400, 10'd400, 10'd249, 10'd249, 10'd240},
   parameter logic [9:0]              HALF_W          = 10'd13,
   parameter logic [9:0]              HALF_H          = 10'd13,
   parameter logic [15:0]             RESPAWN_FRAMES  = 16'd120,
   parameter logic [15:0]             LIFETIME_FRAMES = 16'd600,
   parameter logic [7:0]              LFSR_SEED       = 8'hA5
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic                    frame_clk,
   input  logic [NUM_ITEMS-1:0]    collision,
   input  logic [9:0]              DrawX,
   input  logic [9:0]              DrawY,
   output logic [10*NUM_ITEMS-1:0] itemX,
   output logic [10*NUM_ITEMS-1:0] itemY,
   output logic [NUM_ITEMS-1:0]    active,
   output logic [NUM_ITEMS-1:0]    collected,
   output logic                    is_item,
   output logic [1:0]              item_idx
);

   typedef enum logic {ST_ACTIVE, ST_COOLDOWN} item_state_t;

   item_state_t          state_q [NUM_ITEMS];
   item_state_t          state_d [NUM_ITEMS];
   logic [15:0]          cnt_q   [NUM_ITEMS];
   logic [15:0]          cnt_d   [NUM_ITEMS];
   logic [2:0]           pt_q    [NUM_ITEMS];
   logic [2:0]           pt_d    [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] collected_d;

   logic       frame_dly;
   logic       tick;
   logic [7:0] lfsr;
   logic [2:0] base;
   logic [9:0] tab_x [8];
   logic [9:0] tab_y [8];

   // Unused table slots are tied to zero so pt-indexed lookups never select out of range.
   for (genvar k = 0; k < 8; k++) begin : g_tab
      if (k < NUM_SPAWN) begin : g_used
         assign tab_x[k] = SPAWN_X[10*k +: 10];
         assign tab_y[k] = SPAWN_Y[10*k +: 10];
      end else begin : g_unused
         assign tab_x[k] = '0;
         assign tab_y[k] = '0;
      end
   end

   assign base = 3'(lfsr % 8'(NUM_SPAWN));

   always_ff @(posedge Clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!Reset_n) begin
         frame_dly   <= 1'b0;
         tick        <= 1'b0;
         lfsr        <= LFSR_SEED;
         collected   <= '0;
         // NOTE: the per-item arrays are small register banks, not RAM, so they are
         // reset explicitly to start every item ACTIVE at its home point.
         for (int i = 0; i < NUM_ITEMS; i++) begin
            state_q[i] <= ST_ACTIVE;
            cnt_q[i]   <= '0;
            pt_q[i]    <= 3'(i % NUM_SPAWN);
         end
      end else begin
         frame_dly <= frame_clk;
         tick      <= frame_clk & ~frame_dly;
         if (tick) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         collected <= collected_d;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            pt_q[i]    <= pt_d[i];
         end
      end
   end

   logic [7:0] held;
   logic       found;
   logic [2:0] pick;
   logic [3:0] cand;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      held        = '0;
      found       = 1'b0;
      pick        = '0;
      cand        = '0;
      collected_d = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (state_q[i] == ST_ACTIVE) held[pt_q[i]] = 1'b1;
      end
      for (int i = 0; i < NUM_ITEMS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         pt_d[i]    = pt_q[i];
         found      = 1'b0;
         pick       = '0;
         case (state_q[i])
            ST_ACTIVE: begin
               if (collision[i]) begin
                  state_d[i]     = ST_COOLDOWN;
                  cnt_d[i]       = '0;
                  collected_d[i] = 1'b1;
               end else if (tick && LIFETIME_FRAMES != 16'd0) begin
                  if (cnt_q[i] == LIFETIME_FRAMES - 16'd1) begin
                     state_d[i] = ST_COOLDOWN;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end
               end
            end
            ST_COOLDOWN: begin
               if (tick) begin
                  if (cnt_q[i] < RESPAWN_FRAMES - 16'd1) begin
                     cnt_d[i] = cnt_q[i] + 16'd1;
                  end else begin
                     for (int k = 0; k < NUM_SPAWN; k++) begin
                        cand = {1'b0, base} + 4'(k);
                        if (cand >= 4'(NUM_SPAWN)) cand = cand - 4'(NUM_SPAWN);
                        if (!found && !held[cand[2:0]]) begin
                           found = 1'b1;
                           pick  = cand[2:0];
                        end
                     end
                     // A claimed point blocks higher-index items spawning on this tick.
                     if (found) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = '0;
                        pt_d[i]    = pick;
                        held[pick] = 1'b1;
                     end
                  end
               end
            end
            default: state_d[i] = ST_ACTIVE;
         endcase
      end
   end

   function automatic logic box_hit(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] cx, input logic [9:0] cy);
      return ({1'b0, px} + {1'b0, HALF_W} >= {1'b0, cx}) &&
             ({1'b0, px} <= {1'b0, cx} + {1'b0, HALF_W}) &&
             ({1'b0, py} + {1'b0, HALF_H} >= {1'b0, cy}) &&
             ({1'b0, py} <= {1'b0, cy} + {1'b0, HALF_H});
   endfunction

   // Scanning from the top index down leaves the lowest hitting index in item_idx.
   always_comb begin
      itemX    = '0;
      itemY    = '0;
      active   = '0;
      is_item  = 1'b0;
      item_idx = '0;
      for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
         itemX[10*i +: 10] = tab_x[pt_q[i]];
         itemY[10*i +: 10] = tab_y[pt_q[i]];
         active[i]         = (state_q[i] == ST_ACTIVE);
         if (active[i] && box_hit(DrawX, DrawY, tab_x[pt_q[i]], tab_y[pt_q[i]])) begin
            is_item  = 1'b1;
            item_idx = 2'(i);
         end
      end
   end

endmodule

// File: tb/tb_powerup_spawner.sv
// Directed bench: four configurations of powerup_spawner covering reset, collection,
// expiry, probe wrap on a crowded table, same-cycle collision/expiry and edge boxes.
module tb_powerup_spawner;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       Reset_n;
   logic [9:0] DrawX, DrawY;
   logic       fc_m, fc_e, fc_x, fc_g;
   logic [1:0] col_m, col_e, col_x;
   logic [0:0] col_g;

   logic [19:0] m_x, m_y, e_x, e_y, x_x, x_y;
   logic [9:0]  g_x, g_y;
   logic [1:0]  m_act, m_col, e_act, e_col, x_act, x_col;
   logic [0:0]  g_act, g_col;
   logic        m_hit, e_hit, x_hit, g_hit;
   logic [1:0]  m_idx, e_idx, x_idx, g_idx;

   int n_cmp = 0;
   int n_err = 0;
   int pulses_m0 = 0, pulses_e0 = 0, pulses_e1 = 0;

   int tx[5] = '{320, 180, 461, 30, 610};
   int ty[5] = '{240, 249, 249, 400, 400};

   powerup_spawner u_main (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(fc_m), .collision(col_m),
      .DrawX(DrawX), .DrawY(DrawY), .itemX(m_x), .itemY(m_y), .active(m_act),
      .collected(m_col), .is_item(m_hit), .item_idx(m_idx));

   powerup_spawner #(.RESPAWN_FRAMES(16'd2), .LIFETIME_FRAMES(16'd3)) u_exp (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(fc_e), .collision(col_e),
      .DrawX(DrawX), .DrawY(DrawY), .itemX(e_x), .itemY(e_y), .active(e_act),
      .collected(e_col), .is_item(e_hit), .item_idx(e_idx));

   powerup_spawner #(.NUM_SPAWN(2), .SPAWN_X({10'd500, 10'd100}), .SPAWN_Y({10'd300, 10'd200}),
                     .RESPAWN_FRAMES(16'd1)) u_exh (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(fc_x), .collision(col_x),
      .DrawX(DrawX), .DrawY(DrawY), .itemX(x_x), .itemY(x_y), .active(x_act),
      .collected(x_col), .is_item(x_hit), .item_idx(x_idx));

   powerup_spawner #(.NUM_ITEMS(1), .NUM_SPAWN(2), .SPAWN_X({10'd600, 10'd5}),
                     .SPAWN_Y({10'd100, 10'd470})) u_edge (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(fc_g), .collision(col_g),
      .DrawX(DrawX), .DrawY(DrawY), .itemX(g_x), .itemY(g_y), .active(g_act),
      .collected(g_col), .is_item(g_hit), .item_idx(g_idx));

   always @(negedge Clk) begin
      if (m_col[0] === 1'b1) pulses_m0++;
      if (e_col[0] === 1'b1) pulses_e0++;
      if (e_col[1] === 1'b1) pulses_e1++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
      logic [7:0] s;
      s = v;
      for (int k = 0; k < n; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      return s;
   endfunction

   // One frame: frame_clk high for two cycles; optional collision on u_exp item 0 lands
   // on the cycle the internal tick is consumed.
   task automatic do_tick(input logic [2:0] sel, input logic hit_e0);
      @(negedge Clk);
      fc_m = sel[0]; fc_e = sel[1]; fc_x = sel[2];
      @(negedge Clk);
      col_e[0] = hit_e0;
      @(negedge Clk);
      col_e[0] = 1'b0;
      fc_m = 1'b0; fc_e = 1'b0; fc_x = 1'b0;
      @(negedge Clk);
   endtask

   task automatic pulse_collision(input int which);
      @(negedge Clk);
      if (which == 0) col_m = 2'b01; else col_x = 2'b01;
      @(negedge Clk);
      col_m = 2'b00; col_x = 2'b00;
   endtask

   initial begin
      int b, p0, p1, pe0, pe1;
      Reset_n = 1'b0;
      fc_m = 1'b0; fc_e = 1'b0; fc_x = 1'b0; fc_g = 1'b0;
      col_m = '0; col_e = '0; col_x = '0; col_g = '0;
      DrawX = 10'd320; DrawY = 10'd240;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Reset state and hit test
      check("rst_active", 32'(m_act), 32'd3);
      check("rst_x0", 32'(m_x[9:0]), 32'd320);
      check("rst_y0", 32'(m_y[9:0]), 32'd240);
      check("rst_x1", 32'(m_x[19:10]), 32'd180);
      check("rst_y1", 32'(m_y[19:10]), 32'd249);
      check("rst_collected", 32'(m_col), 32'd0);
      check("rst_hit", 32'(m_hit), 32'd1);
      check("rst_idx", 32'(m_idx), 32'd0);
      DrawX = 10'd180; DrawY = 10'd249; #1;
      check("hit_item1", 32'(m_hit), 32'd1);
      check("idx_item1", 32'(m_idx), 32'd1);
      DrawX = 10'd0; DrawY = 10'd0; #1;
      check("miss_hit", 32'(m_hit), 32'd0);
      check("miss_idx", 32'(m_idx), 32'd0);

      // Collection, cooldown ignoring collision, respawn after 120 ticks
      pulse_collision(0);
      check("col_pulse", 32'(m_col), 32'd1);
      check("col_inactive", 32'(m_act), 32'd2);
      @(negedge Clk);
      check("col_pulse_end", 32'(m_col), 32'd0);
      repeat (5) do_tick(3'b001, 1'b0);
      pulse_collision(0);
      check("cd_ignore_col", 32'(m_col), 32'd0);
      check("cd_still_inactive", 32'(m_act), 32'd2);
      repeat (114) do_tick(3'b001, 1'b0);
      check("no_early_spawn", 32'(m_act), 32'd2);
      check("cd_x_hold", 32'(m_x[9:0]), 32'd320);
      do_tick(3'b001, 1'b0);
      b = int'(lfsr_adv(8'hA5, 119)) % 5;
      if (b == 1) b = 2;
      check("respawn_active", 32'(m_act), 32'd3);
      check("respawn_x", 32'(m_x[9:0]), 32'(tx[b]));
      check("respawn_y", 32'(m_y[9:0]), 32'(ty[b]));
      check("respawn_item1_x", 32'(m_x[19:10]), 32'd180);
      check("main_pulses", 32'(pulses_m0), 32'd1);

      // Expiry with RESPAWN=2, LIFETIME=3
      pe0 = pulses_e0; pe1 = pulses_e1;
      repeat (2) do_tick(3'b010, 1'b0);
      check("exp_tick2", 32'(e_act), 32'd3);
      do_tick(3'b010, 1'b0);
      check("exp_tick3", 32'(e_act), 32'd0);
      do_tick(3'b010, 1'b0);
      check("exp_tick4", 32'(e_act), 32'd0);
      do_tick(3'b010, 1'b0);
      p0 = int'(lfsr_adv(8'hA5, 4)) % 5;
      p1 = (p0 + 1) % 5;
      check("exp_respawn", 32'(e_act), 32'd3);
      check("exp_x0", 32'(e_x[9:0]), 32'(tx[p0]));
      check("exp_x1", 32'(e_x[19:10]), 32'(tx[p1]));
      check("exp_y1", 32'(e_y[19:10]), 32'(ty[p1]));
      check("exp_points_differ", 32'((e_x[9:0] != e_x[19:10]) || (e_y[9:0] != e_y[19:10])), 32'd1);
      check("exp_no_pulse0", 32'(pulses_e0 - pe0), 32'd0);

      // Collision on the same cycle as expiry
      repeat (2) do_tick(3'b010, 1'b0);
      check("sim_before", 32'(e_act), 32'd3);
      do_tick(3'b010, 1'b1);
      check("sim_cooldown", 32'(e_act), 32'd0);
      check("sim_one_pulse", 32'(pulses_e0 - pe0), 32'd1);
      check("sim_no_pulse1", 32'(pulses_e1 - pe1), 32'd0);
      do_tick(3'b010, 1'b0);
      check("sim_wait", 32'(e_act), 32'd0);
      do_tick(3'b010, 1'b0);
      p0 = int'(lfsr_adv(8'hA5, 9)) % 5;
      p1 = (p0 + 1) % 5;
      check("sim_respawn", 32'(e_act), 32'd3);
      check("sim_x0", 32'(e_x[9:0]), 32'(tx[p0]));
      check("sim_x1", 32'(e_x[19:10]), 32'(tx[p1]));
      check("sim_pulse_total", 32'(pulses_e0 - pe0), 32'd1);

      // Exhaustion: two points, item1 holds point 1; LFSR index 1 then 0
      check("exh_rst", 32'(x_act), 32'd3);
      pulse_collision(1);
      check("exh_collected", 32'(x_act), 32'd2);
      do_tick(3'b100, 1'b0);
      check("exh_wrap_active", 32'(x_act), 32'd3);
      check("exh_wrap_x0", 32'(x_x[9:0]), 32'd100);
      check("exh_wrap_y0", 32'(x_y[9:0]), 32'd200);
      check("exh_x1", 32'(x_x[19:10]), 32'd500);
      pulse_collision(1);
      do_tick(3'b100, 1'b0);
      check("exh_base0_active", 32'(x_act), 32'd3);
      check("exh_base0_x0", 32'(x_x[9:0]), 32'd100);

      // Edge box at (5,470)
      DrawY = 10'd470;
      for (int x = 0; x <= 20; x++) begin
         DrawX = 10'(x); #1;
         check($sformatf("edge_x%0d", x), 32'(g_hit), (x <= 18) ? 32'd1 : 32'd0);
      end
      DrawX = 10'd639; #1;
      check("edge_x639", 32'(g_hit), 32'd0);
      DrawX = 10'd5; DrawY = 10'd456; #1;
      check("edge_y456", 32'(g_hit), 32'd0);
      DrawY = 10'd457; #1;
      check("edge_y457", 32'(g_hit), 32'd1);
      DrawY = 10'd479; #1;
      check("edge_y479", 32'(g_hit), 32'd1);
      check("edge_idx", 32'(g_idx), 32'd0);

      // Reset mid-cooldown discards progress
      pulse_collision(0);
      repeat (3) do_tick(3'b001, 1'b0);
      check("pre_reset_cd", 32'(m_act), 32'd2);
      @(negedge Clk);
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      check("rerst_active", 32'(m_act), 32'd3);
      check("rerst_x0", 32'(m_x[9:0]), 32'd320);
      check("rerst_exp_active", 32'(e_act), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
